serial_tx: RTL and testbench

Parallel-to-serial transmitter: the driving end of the single-bit serial data path our registered capture stages sample. Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per clock on a registered serial line, with a frame-valid strobe and last-bit marker. Back-to-back words stream with no idle cycle. Sits between a word-producing block and any bit-serial sink clocked on the same `clk`.

---
 rtl/serial_tx_pkg.sv | 20 ++
 rtl/serial_tx_shreg.sv | 46 ++++
 rtl/serial_tx.sv | 148 ++++++++++++++
 tb/tb_serial_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared types and sizing helpers for the serial transmitter.
// Optional parity framing is selected by the SERIAL_TX_PARITY_EN macro.
package serial_tx_pkg;

  // Frame sequencer states; PARITY is reachable only in parity builds.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } tx_state_t;

  // Smallest supported word width.
  localparam int unsigned TX_MIN_WIDTH = 2;

  // Bit-counter width for a given word width (counter spans 0..width-1).
  function automatic int unsigned tx_cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_tx_shreg.sv
// serial_tx_shreg: WIDTH-bit shift register feeding the serial line.
// The head bit is a flop output and drives sd_o directly; vacated positions
// take fill_i so the register drains to zero by the end of a frame (and can
// carry the parity bit into the head position in SERIAL_TX_PARITY_EN builds).
module serial_tx_shreg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             fill_i,
  output logic             head_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Load has priority over shift; direction picks which end leaves first.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], fill_i};
      end else begin
        sr_d = {fill_i, sr_q[WIDTH-1:1]};
      end
    end
  end

  // Shift register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign head_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial transmitter with valid/ready word intake,
// registered serial data, frame-valid strobe and last-bit marker.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit to every frame.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             sd_o,
  output logic             sv_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int unsigned      CNT_W    = tx_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sv_q, sv_d;
  logic             last_q, last_d;
  logic             accept;
  logic             load;
  logic             shift;
  logic             fill;
  logic             head;

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q, parity_d;

  // Parity is captured with the word so later data_i changes cannot affect it.
  always_comb begin
    parity_d = parity_q;
    if (accept) begin
      parity_d = ^data_i;
    end
  end

  // Parity bit storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  // Parity is fed in on the first shift so it reaches the head exactly after
  // the last data bit; all later fills are zero so the register drains clean.
  assign fill = (state_q == SHIFT && cnt_q == '0) ? parity_q : 1'b0;
`else
  assign fill = 1'b0;
`endif

  // Ready comes only from registers: idle, or showing the frame's final bit.
  assign ready_o = (state_q == IDLE) || last_q;
  assign accept  = valid_i && ready_o;

  // Next-state, counter and strobe decode; an accept always restarts a frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sv_d    = 1'b0;
    last_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    if (accept) begin
      load    = 1'b1;
      cnt_d   = '0;
      state_d = SHIFT;
      sv_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          shift = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
            sv_d    = 1'b1;
            last_d  = 1'b1;
`else
            state_d = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            sv_d  = 1'b1;
`ifndef SERIAL_TX_PARITY_EN
            last_d = ((cnt_q + CNT_W'(1)) == CNT_LAST);
`endif
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          shift   = 1'b1;
          state_d = IDLE;
        end
`endif
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sequencer and output strobe registers; reset wins over a same-edge accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sv_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sv_q    <= sv_d;
      last_q  <= last_d;
    end
  end

  serial_tx_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .shift_i(shift),
    .data_i (data_i),
    .fill_i (fill),
    .head_o (head)
  );

  assign sd_o   = head;
  assign sv_o   = sv_q;
  assign last_o = last_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: scoreboard bench for serial_tx (WIDTH=8, MSB-first main DUT,
// plus an LSB-first instance). Honours SERIAL_TX_PARITY_EN like the RTL.
module tb_serial_tx;

  localparam int unsigned W = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned FRAME_LEN = W + PAR;

  logic         clk;
  logic         rst;
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         ready_o, sd_o, sv_o, last_o, busy_o;

  logic [W-1:0] data_l;
  logic         valid_l;
  logic         ready_l, sd_l, sv_l, last_l, busy_l;

  int unsigned  errors = 0;
  int unsigned  checks = 0;
  logic [1:0]   exp_q[$];
  logic [1:0]   exp_bit;

  serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .sd_o(sd_o), .sv_o(sv_o), .last_o(last_o), .busy_o(busy_o)
  );

  serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .data_i(data_l), .valid_i(valid_l),
    .ready_o(ready_l), .sd_o(sd_l), .sv_o(sv_l), .last_o(last_l), .busy_o(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {sd, last} sequence for one MSB-first frame.
  function automatic void push_frame(input logic [W-1:0] d);
    for (int k = 0; k < W; k++) begin
      logic b;
      b = d[W-1-k];
      exp_q.push_back({b, (k == W - 1) && (PAR == 0)});
    end
    if (PAR != 0) exp_q.push_back({^d, 1'b1});
  endfunction

  // Every frame bit on the main DUT is popped against the scoreboard.
  always @(negedge clk) begin
    if (sv_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_bit: sd_o=%b last_o=%b, required no frame bit", sd_o, last_o);
      end else begin
        exp_bit = exp_q.pop_front();
        if ({sd_o, last_o} !== exp_bit) begin
          errors++;
          $display("FAIL sb_bit: {sd_o,last_o}=%b required %b", {sd_o, last_o}, exp_bit);
        end
      end
    end
  end

  // Drive one cycle from a negedge; predicts acceptance from the registered ready.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, output logic acc);
    acc     = v && (ready_o === 1'b1) && !r;
    rst     = r;
    valid_i = v;
    data_i  = d;
    if (acc) push_frame(d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic acc;
    step(1'b1, 8'hAA, 1'b1, acc);
    step(1'b1, 8'hAA, 1'b1, acc);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ready_o); end
    checks++; if (sd_o !== 1'b0) begin errors++; $display("FAIL reset_sd: got %b required 0", sd_o); end
    checks++; if (sv_o !== 1'b0) begin errors++; $display("FAIL reset_sv: got %b required 0", sv_o); end
    checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b required 0", last_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    step(1'b0, 8'h00, 1'b0, acc);
    checks++;
    if ({sv_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL reset_no_accept: sv_o,busy_o=%b required 00", {sv_o, busy_o});
    end
  endtask

  task automatic test_single_word(input logic [W-1:0] w);
    logic acc;
    int unsigned svc = 0;
    step(1'b1, w, 1'b0, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single_accept: got %b required 1", acc); end
    for (int c = 0; c < FRAME_LEN; c++) begin
      if (sv_o === 1'b1) svc++;
      checks++;
      if ({ready_o, busy_o} !== {(c == FRAME_LEN - 1), 1'b1}) begin
        errors++;
        $display("FAIL single_ready_busy c=%0d: got %b required %b", c, {ready_o, busy_o}, {(c == FRAME_LEN - 1), 1'b1});
      end
      step(1'b0, 8'h00, 1'b0, acc);
    end
    checks++; if (svc != FRAME_LEN) begin errors++; $display("FAIL single_len: got %0d required %0d", svc, FRAME_LEN); end
    checks++;
    if ({sv_o, busy_o, ready_o, sd_o} !== 4'b0010) begin
      errors++; $display("FAIL single_idle: sv,busy,ready,sd=%b required 0010", {sv_o, busy_o, ready_o, sd_o});
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [W-1:0] words[2];
    int unsigned idx = 0;
    int unsigned svc = 0;
    words[0] = 8'h3C;
    words[1] = 8'hC3;
    step(1'b1, words[0], 1'b0, acc);
    if (acc) idx = 1;
    for (int c = 0; c < 2 * FRAME_LEN; c++) begin
      if (sv_o === 1'b1) svc++;
      checks++;
      if (ready_o !== ((c == FRAME_LEN - 1) || (c == 2 * FRAME_LEN - 1))) begin
        errors++; $display("FAIL b2b_ready c=%0d: got %b", c, ready_o);
      end
      if (idx < 2) step(1'b1, words[idx], 1'b0, acc);
      else         step(1'b0, 8'h00, 1'b0, acc);
      if (acc) idx++;
    end
    checks++; if (svc != 2 * FRAME_LEN) begin errors++; $display("FAIL b2b_contiguous: got %0d required %0d", svc, 2 * FRAME_LEN); end
    checks++; if (idx != 2) begin errors++; $display("FAIL b2b_accepts: got %0d required 2", idx); end
    checks++; if (sv_o !== 1'b0) begin errors++; $display("FAIL b2b_idle: sv_o=%b required 0", sv_o); end
  endtask

  task automatic test_mid_frame();
    logic acc;
    int unsigned svc = 0;
    step(1'b1, 8'hF0, 1'b0, acc);
    for (int c = 0; c < 2 * FRAME_LEN; c++) begin
      if (sv_o === 1'b1) svc++;
      if (c < FRAME_LEN - 1) begin
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready c=%0d: got %b required 0", c, ready_o); end
      end
      step(c < FRAME_LEN, 8'h0F, 1'b0, acc);
    end
    checks++; if (svc != 2 * FRAME_LEN) begin errors++; $display("FAIL mid_contiguous: got %0d required %0d", svc, 2 * FRAME_LEN); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_idle: busy_o=%b required 0", busy_o); end
  endtask

  task automatic test_reset_mid_frame();
    logic acc;
    int unsigned svc = 0;
    step(1'b1, 8'hFF, 1'b0, acc);
    for (int c = 0; c < 4; c++) step(1'b0, 8'h00, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, acc);
    checks++;
    if ({sd_o, sv_o, last_o, busy_o, ready_o} !== 5'b00001) begin
      errors++; $display("FAIL rstmid_outputs: sd,sv,last,busy,ready=%b required 00001", {sd_o, sv_o, last_o, busy_o, ready_o});
    end
    exp_q.delete();
    step(1'b1, 8'h01, 1'b0, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL rstmid_accept: got %b required 1", acc); end
    for (int c = 0; c < FRAME_LEN; c++) begin
      if (sv_o === 1'b1) svc++;
      step(1'b0, 8'h00, 1'b0, acc);
    end
    checks++; if (svc != FRAME_LEN) begin errors++; $display("FAIL rstmid_len: got %0d required %0d", svc, FRAME_LEN); end
    checks++; if (sv_o !== 1'b0) begin errors++; $display("FAIL rstmid_idle: sv_o=%b required 0", sv_o); end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] w;
    logic         b;
    w = 8'h01;
    checks++; if (ready_l !== 1'b1) begin errors++; $display("FAIL lsb_ready: got %b required 1", ready_l); end
    valid_l = 1'b1;
    data_l  = w;
    @(negedge clk);
    valid_l = 1'b0;
    data_l  = 8'hFF;
    for (int k = 0; k < FRAME_LEN; k++) begin
      b = (k < W) ? w[k] : ^w;
      checks++;
      if ({sd_l, sv_l, last_l} !== {b, 1'b1, (k == FRAME_LEN - 1)}) begin
        errors++;
        $display("FAIL lsb_bit k=%0d: sd,sv,last=%b required %b", k, {sd_l, sv_l, last_l}, {b, 1'b1, (k == FRAME_LEN - 1)});
      end
      @(negedge clk);
    end
    checks++; if ({sv_l, busy_l} !== 2'b00) begin errors++; $display("FAIL lsb_idle: sv,busy=%b required 00", {sv_l, busy_l}); end
  endtask

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    valid_l = 1'b0;
    data_l  = '0;
    @(negedge clk);
    test_reset();
    test_single_word(8'hA5);
`ifdef SERIAL_TX_PARITY_EN
    test_single_word(8'h07);
`endif
    test_back_to_back();
    test_mid_frame();
    test_reset_mid_frame();
    test_lsb_first();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d bits never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
